// File: rtl/jogador_grade.sv
// Light-cycle player engine: advances the head one cell per tick, checks the arena
// walls and the shared trail RAM, and marks every visited cell with PLAYER_ID.
module jogador_grade #(
    parameter logic [7:0] PLAYER_ID = 8'h01,
    parameter int CELL      = 8,
    parameter int H_CELLS   = 80,
    parameter int START_CX  = 27,
    parameter int START_CY  = 30,
    parameter int START_DIR = 0,
    parameter int CX_MIN    = 2,
    parameter int CX_MAX    = 77,
    parameter int CY_MIN    = 2,
    parameter int CY_MAX    = 57,
    parameter int TICK_DIV  = 1000000,
    parameter int ADDR_W    = 13
) (
    input  logic              VGA_CLK,
    input  logic              reset,
    input  logic              reiniciar,
    input  logic              pausa,
    input  logic              key_ah,
    input  logic              key_h,
    input  logic [9:0]        next_x,
    input  logic [9:0]        next_y,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    input  logic [7:0]        rd_data,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              wr_ack,
    output logic [6:0]        cx,
    output logic [5:0]        cy,
    output logic [1:0]        sentido,
    output logic              fim_de_jogo,
    output logic [1:0]        colisao,
    output logic              sprite_on
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam int SHIFT = $clog2(CELL);
    localparam logic signed [8:0] X_LO = 9'(CX_MIN);
    localparam logic signed [8:0] X_HI = 9'(CX_MAX);
    localparam logic signed [8:0] Y_LO = 9'(CY_MIN);
    localparam logic signed [8:0] Y_HI = 9'(CY_MAX);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_CALC, S_BOUND, S_READ, S_WRITE, S_DEAD
    } state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0] tick_cnt;
    logic             tick_pend;
    logic             counting, tick_wrap;
    logic             key_h_s, key_h_q, key_ah_s, key_ah_q;
    logic             fall_h, fall_ah;
    logic             turn_valid;
    logic [1:0]       turn;
    logic [1:0]       dir_next;
    logic signed [8:0] cx_s, cy_s, nx_calc, ny_calc;
    logic signed [8:0] nx, ny;
    logic             out_of_bounds;

    function automatic logic [ADDR_W-1:0] cell_addr(input int x, input int y);
        int a;
        a = y * H_CELLS + x;
        return a[ADDR_W-1:0];
    endfunction

    assign counting  = (state != S_DEAD) && !pausa;
    assign tick_wrap = (tick_cnt == CNT_LAST);

    always_ff @(posedge VGA_CLK or negedge reset) begin
        if (!reset) begin
            tick_cnt  <= '0;
            tick_pend <= 1'b0;
        end else begin
            if (counting)
                tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
            if (reiniciar)
                tick_pend <= 1'b0;
            else if (counting && tick_wrap)
                tick_pend <= 1'b1;
            else if (state == S_IDLE)
                tick_pend <= 1'b0;
        end
    end

    // Buttons are asynchronous: one sync stage, then falling-edge detect on the synced copy.
    assign fall_h  = key_h_q & ~key_h_s;
    assign fall_ah = key_ah_q & ~key_ah_s;

    always_ff @(posedge VGA_CLK or negedge reset) begin
        if (!reset) begin
            key_h_s    <= 1'b1;
            key_h_q    <= 1'b1;
            key_ah_s   <= 1'b1;
            key_ah_q   <= 1'b1;
            turn_valid <= 1'b0;
            turn       <= 2'd0;
        end else begin
            key_h_s  <= key_h;
            key_h_q  <= key_h_s;
            key_ah_s <= key_ah;
            key_ah_q <= key_ah_s;
            if (reiniciar) begin
                turn_valid <= 1'b0;
            end else if ((!turn_valid || state == S_CALC) && (fall_h ^ fall_ah)) begin
                turn_valid <= 1'b1;
                turn       <= fall_h ? 2'd1 : 2'd3;
            end else if (state == S_CALC) begin
                turn_valid <= 1'b0;
            end
        end
    end

    assign dir_next = turn_valid ? sentido + turn : sentido;
    assign cx_s     = signed'({2'b00, cx});
    assign cy_s     = signed'({3'b000, cy});

    always_comb begin
        nx_calc = cx_s;
        ny_calc = cy_s;
        case (dir_next)
            2'd0:    nx_calc = cx_s + 9'sd1;
            2'd1:    ny_calc = cy_s + 9'sd1;
            2'd2:    nx_calc = cx_s - 9'sd1;
            default: ny_calc = cy_s - 9'sd1;
        endcase
    end

    assign out_of_bounds = (nx < X_LO) || (nx > X_HI) || (ny < Y_LO) || (ny > Y_HI);

    always_comb begin
        state_nx = state;
        case (state)
            S_INIT:  if (wr_ack) state_nx = S_IDLE;
            S_IDLE:  if (tick_pend) state_nx = S_CALC;
            S_CALC:  state_nx = S_BOUND;
            S_BOUND: state_nx = out_of_bounds ? S_DEAD : S_READ;
            S_READ:  if (rd_valid) state_nx = (rd_data != 8'h00) ? S_DEAD : S_WRITE;
            S_WRITE: if (wr_ack) state_nx = S_IDLE;
            S_DEAD:  state_nx = S_DEAD;
            default: state_nx = S_INIT;
        endcase
        if (reiniciar)
            state_nx = S_INIT;
    end

    // Requests are registered from the next state so they are low in reset and drop right after valid/ack.
    always_ff @(posedge VGA_CLK or negedge reset) begin
        if (!reset) begin
            state   <= S_INIT;
            rd_req  <= 1'b0;
            wr_req  <= 1'b0;
            cx      <= 7'(START_CX);
            cy      <= 6'(START_CY);
            sentido <= 2'(START_DIR);
            colisao <= 2'd0;
            nx      <= 9'(START_CX);
            ny      <= 9'(START_CY);
        end else begin
            state  <= state_nx;
            rd_req <= (state_nx == S_READ);
            wr_req <= (state_nx == S_INIT) || (state_nx == S_WRITE);
            if (reiniciar) begin
                cx      <= 7'(START_CX);
                cy      <= 6'(START_CY);
                sentido <= 2'(START_DIR);
                colisao <= 2'd0;
            end else begin
                case (state)
                    S_CALC: begin
                        sentido <= dir_next;
                        nx      <= nx_calc;
                        ny      <= ny_calc;
                    end
                    S_BOUND: if (out_of_bounds) colisao <= 2'd1;
                    S_READ:  if (rd_valid && rd_data != 8'h00) colisao <= 2'd2;
                    S_WRITE: if (wr_ack) begin
                        cx <= nx[6:0];
                        cy <= ny[5:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rd_addr     = cell_addr(int'(nx), int'(ny));
    assign wr_addr     = (state == S_WRITE) ? rd_addr : cell_addr(int'(cx), int'(cy));
    assign wr_data     = PLAYER_ID;
    assign fim_de_jogo = (state == S_DEAD);

    always_ff @(posedge VGA_CLK or negedge reset) begin
        if (!reset)
            sprite_on <= 1'b0;
        else
            sprite_on <= (10'(next_x >> SHIFT) == 10'(cx)) && (10'(next_y >> SHIFT) == 10'(cy));
    end

endmodule

// File: tb/tb_jogador_grade.sv
// Self-checking bench for jogador_grade: directed corner cases, a sprite vector table
// and randomized games checked against a cell-level model of the player.
module tb_jogador_grade;

    logic        VGA_CLK = 1'b0;
    logic        reset, reiniciar, pausa, key_ah, key_h;
    logic [9:0]  next_x, next_y;
    logic        rd_req, rd_valid, wr_req, wr_ack;
    logic [12:0] rd_addr, wr_addr;
    logic [7:0]  rd_data, wr_data;
    logic [6:0]  cx;
    logic [5:0]  cy;
    logic [1:0]  sentido, colisao;
    logic        fim_de_jogo, sprite_on;

    jogador_grade #(.TICK_DIV(16)) dut (
        .VGA_CLK(VGA_CLK), .reset(reset), .reiniciar(reiniciar), .pausa(pausa),
        .key_ah(key_ah), .key_h(key_h), .next_x(next_x), .next_y(next_y),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .cx(cx), .cy(cy), .sentido(sentido), .fim_de_jogo(fim_de_jogo),
        .colisao(colisao), .sprite_on(sprite_on)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    int tests = 0;
    int fails = 0;

    logic [7:0] trail [0:8191];
    int  rd_delay = 0;
    int  wr_delay = 0;
    bit  rand_delays = 1'b0;
    int  wr_log[$];
    int  rd_starts = 0;

    int  m_cx, m_cy, m_dir, m_col;
    bit  m_dead;
    bit  m_occ [0:8191];

    typedef struct {
        int px;
        int py;
        int exp_sprite;
    } sprite_vec_t;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int lastWrite();
        return (wr_log.size() > 0) ? wr_log[wr_log.size()-1] : -1;
    endfunction

    // RAM responder: serves read and write handshakes and checks request stability.
    task automatic serveRead();
        int  a = int'(rd_addr);
        int  d = rand_delays ? int'($urandom_range(2, 0)) : rd_delay;
        bit  aborted = 1'b0;
        rd_starts++;
        for (int i = 0; i < d; i++) begin
            @(posedge VGA_CLK); #1;
            if (!rd_req) begin
                aborted = 1'b1;
                break;
            end
            checkOutput("rd_addr_stable", int'(rd_addr), a);
        end
        if (!aborted) begin
            rd_data  = trail[a];
            rd_valid = 1'b1;
            @(posedge VGA_CLK); #1;
            rd_valid = 1'b0;
            rd_data  = 8'h00;
            checkOutput("rd_req_drop", int'(rd_req), 0);
        end
    endtask

    task automatic serveWrite();
        int  a = int'(wr_addr);
        int  d = rand_delays ? int'($urandom_range(2, 0)) : wr_delay;
        bit  aborted = 1'b0;
        checkOutput("wr_data_id", int'(wr_data), 8'h01);
        for (int i = 0; i < d; i++) begin
            @(posedge VGA_CLK); #1;
            if (!wr_req) begin
                aborted = 1'b1;
                break;
            end
            checkOutput("wr_addr_stable", int'(wr_addr), a);
        end
        if (!aborted) begin
            wr_ack = 1'b1;
            @(posedge VGA_CLK); #1;
            wr_ack = 1'b0;
            checkOutput("wr_req_drop", int'(wr_req), 0);
            trail[a] = 8'h01;
            wr_log.push_back(a);
        end
    endtask

    initial begin
        rd_valid = 1'b0;
        wr_ack   = 1'b0;
        rd_data  = 8'h00;
        forever begin
            @(posedge VGA_CLK); #1;
            if (reset) begin
                checkOutput("req_exclusive", int'(rd_req && wr_req), 0);
                if (rd_req) serveRead();
                if (wr_req) serveWrite();
            end
        end
    end

    // Reference player: one cell per step, turn applied first, walls then trail.
    function automatic int modelStep(input bit has_turn, input int turn);
        int nx, ny, a;
        if (has_turn) m_dir = (m_dir + turn) % 4;
        nx = m_cx + ((m_dir == 0) ? 1 : (m_dir == 2) ? -1 : 0);
        ny = m_cy + ((m_dir == 1) ? 1 : (m_dir == 3) ? -1 : 0);
        if (nx < 2 || nx > 77 || ny < 2 || ny > 57) begin
            m_dead = 1'b1;
            m_col  = 1;
            return -1;
        end
        a = ny * 80 + nx;
        if (m_occ[a]) begin
            m_dead = 1'b1;
            m_col  = 2;
            return -1;
        end
        m_occ[a] = 1'b1;
        m_cx = nx;
        m_cy = ny;
        return a;
    endfunction

    task automatic waitStep(output bit ok);
        int n0 = wr_log.size();
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge VGA_CLK);
            if (wr_log.size() > n0 || fim_de_jogo) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("step_timeout", 0, 1);
    endtask

    task automatic waitRdReq(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge VGA_CLK);
            if (rd_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("rd_req_timeout", 0, 1);
    endtask

    task automatic pulseKey(input bit h, input bit ah);
        @(negedge VGA_CLK);
        key_h  = ~h;
        key_ah = ~ah;
        @(negedge VGA_CLK);
        key_h  = 1'b1;
        key_ah = 1'b1;
    endtask

    task automatic restart();
        @(negedge VGA_CLK);
        reiniciar = 1'b1;
        @(negedge VGA_CLK);
        reiniciar = 1'b0;
    endtask

    task automatic clearTrail();
        for (int a = 0; a < 8192; a++) begin
            trail[a] = 8'h00;
            m_occ[a] = 1'b0;
        end
    endtask

    task automatic applyStimulus(input sprite_vec_t v);
        @(negedge VGA_CLK);
        next_x = 10'(v.px);
        next_y = 10'(v.py);
        @(negedge VGA_CLK);
    endtask

    task automatic checkPose(input string tag);
        checkOutput({tag, "_cx"}, int'(cx), m_cx);
        checkOutput({tag, "_cy"}, int'(cy), m_cy);
        checkOutput({tag, "_dir"}, int'(sentido), m_dir);
        checkOutput({tag, "_dead"}, int'(fim_de_jogo), int'(m_dead));
        checkOutput({tag, "_col"}, int'(colisao), m_col);
    endtask

    task automatic runEpisode();
        bit ok;
        int kind, turn, exp_a;
        bit has_turn;
        clearTrail();
        for (int k = 0; k < 30; k++) begin
            int x = int'($urandom_range(77, 2));
            int y = int'($urandom_range(57, 2));
            int a = y * 80 + x;
            if (a != 2427) begin
                trail[a] = 8'(k + 2);
                m_occ[a] = 1'b1;
            end
        end
        restart();
        m_cx = 27; m_cy = 30; m_dir = 0; m_dead = 1'b0; m_col = 0;
        m_occ[2427] = 1'b1;
        rand_delays = 1'b1;
        waitStep(ok);
        checkOutput("ep_init_write", lastWrite(), 2427);
        for (int s = 0; s < 120 && ok && !m_dead; s++) begin
            kind = (s == 0) ? 0 : int'($urandom_range(7, 0));
            has_turn = 1'b0;
            turn = 0;
            case (kind)
                1: begin pulseKey(1, 0); has_turn = 1'b1; turn = 1; end
                2: begin pulseKey(0, 1); has_turn = 1'b1; turn = 3; end
                3: pulseKey(1, 1);
                4: begin pulseKey(1, 0); pulseKey(0, 1); has_turn = 1'b1; turn = 1; end
                5: begin pulseKey(1, 1); pulseKey(0, 1); has_turn = 1'b1; turn = 3; end
                default: ;
            endcase
            exp_a = modelStep(has_turn, turn);
            waitStep(ok);
            checkPose("rand");
            if (exp_a >= 0) checkOutput("rand_wr_addr", lastWrite(), exp_a);
        end
        rand_delays = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        sprite_vec_t vecs [8];
        bit ok;
        int n_rd, n_wr, held;

        vecs[0] = '{216, 240, 1};
        vecs[1] = '{223, 247, 1};
        vecs[2] = '{220, 244, 1};
        vecs[3] = '{224, 240, 0};
        vecs[4] = '{215, 240, 0};
        vecs[5] = '{216, 248, 0};
        vecs[6] = '{216, 239, 0};
        vecs[7] = '{0, 0, 0};

        reset = 1'b0; reiniciar = 1'b0; pausa = 1'b1;
        key_h = 1'b1; key_ah = 1'b1; next_x = 10'd0; next_y = 10'd0;
        clearTrail();
        repeat (3) @(negedge VGA_CLK);
        m_cx = 27; m_cy = 30; m_dir = 0; m_dead = 1'b0; m_col = 0;
        checkPose("reset");
        checkOutput("reset_sprite", int'(sprite_on), 0);
        checkOutput("reset_rd_req", int'(rd_req), 0);
        checkOutput("reset_wr_req", int'(wr_req), 0);

        reset = 1'b1;
        waitStep(ok);
        checkOutput("init_write", lastWrite(), 2427);

        repeat (40) @(negedge VGA_CLK);
        checkPose("pause");
        checkOutput("pause_writes", wr_log.size(), 1);
        checkOutput("pause_reads", rd_starts, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("sprite_%0d_%0d", vecs[i].px, vecs[i].py), int'(sprite_on), vecs[i].exp_sprite);
        end
        pausa = 1'b0;

        waitStep(ok);
        m_cx = 28;
        checkPose("step1");
        checkOutput("step1_write", lastWrite(), 2428);

        pulseKey(1, 0);
        pulseKey(0, 1);
        pulseKey(0, 1);
        waitStep(ok);
        m_cy = 31; m_dir = 1;
        checkPose("key_first");
        checkOutput("key_first_write", lastWrite(), 2508);

        pulseKey(0, 1);
        waitStep(ok);
        m_cx = 29; m_dir = 0;
        checkPose("key_again");
        checkOutput("key_again_write", lastWrite(), 2509);

        for (int i = 0; i < 48 && ok; i++) waitStep(ok);
        m_cx = 77;
        checkPose("wall_edge");
        n_rd = rd_starts;
        n_wr = wr_log.size();
        waitStep(ok);
        m_dead = 1'b1; m_col = 1;
        checkPose("wall_hit");
        checkOutput("wall_no_read", rd_starts, n_rd);
        repeat (40) @(negedge VGA_CLK);
        checkPose("wall_frozen");
        checkOutput("wall_no_req", rd_starts + wr_log.size(), n_rd + n_wr);

        clearTrail();
        trail[2428] = 8'h80;
        restart();
        waitStep(ok);
        m_cx = 27; m_cy = 30; m_dir = 0; m_dead = 1'b0; m_col = 0;
        checkPose("trail_restart");
        checkOutput("trail_init_write", lastWrite(), 2427);
        rd_delay = 5;
        waitRdReq(ok);
        checkOutput("trail_rd_addr", int'(rd_addr), 2428);
        held = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge VGA_CLK);
            if (rd_req && rd_addr == 13'd2428) held++;
        end
        checkOutput("trail_rd_held", held, 5);
        n_wr = wr_log.size();
        waitStep(ok);
        rd_delay = 0;
        m_dead = 1'b1; m_col = 2;
        checkPose("trail_hit");
        checkOutput("trail_no_write", wr_log.size(), n_wr);

        clearTrail();
        restart();
        waitStep(ok);
        waitStep(ok);
        m_cx = 28; m_cy = 30; m_dir = 0; m_dead = 1'b0; m_col = 0;
        checkPose("mid_read_pre");
        rd_delay = 30;
        waitRdReq(ok);
        checkOutput("mid_read_addr", int'(rd_addr), 2429);
        reiniciar = 1'b1;
        @(negedge VGA_CLK);
        m_cx = 27;
        checkOutput("mid_read_rd_drop", int'(rd_req), 0);
        checkOutput("mid_read_wr_req", int'(wr_req), 1);
        checkOutput("mid_read_wr_addr", int'(wr_addr), 2427);
        checkPose("mid_read_restart");
        reiniciar = 1'b0;
        rd_delay = 0;
        waitStep(ok);
        checkOutput("mid_read_rewrite", lastWrite(), 2427);

        for (int ep = 0; ep < 4; ep++) runEpisode();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
